timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  Sequencer for the FF05-FF07 timer (TIMA/TMA/TAC) on top of the divider chain.
//  Picks one divider tap per TAC, counts its falling edges into TIMA and handles overflow.
//  Overflow runs a delayed TMA reload and raises the timer interrupt request.
//  Owns the CPU read/write path for FF05-FF07 and drives the shared data bus d.
// PARAMETERS
//  RELOAD_DELAY  1      M-cycles TIMA reads 8'h00 after overflow before TMA reload (0..3; 0 = reload on wrap)
//  TAC_PAD       8'hF8  constant OR'd into TAC reads (unimplemented bits 7:3)
// PORTS
//  clk         in   1  system clock (4 MHz domain); all state updates on posedge
//  nreset      in   1  asynchronous, active-low reset
//  mcyc        in   1  one-clk strobe, once per M-cycle (every 4 clk)
//  div_4096    in   1  divider tap, TAC[1:0]=00
//  div_262144  in   1  divider tap, TAC[1:0]=01
//  div_65536   in   1  divider tap, TAC[1:0]=10
//  div_16384   in   1  divider tap, TAC[1:0]=11
//  sel_ff05    in   1  address decode TIMA
//  sel_ff06    in   1  address decode TMA
//  sel_ff07    in   1  address decode TAC
//  cpu_wr      in   1  one-clk write strobe
//  cpu_rd      in   1  read enable (level)
//  d_in        in   8  CPU write data
//  d_out       out  8  read data; valid while d_oe
//  d_oe        out  1  = cpu_rd & (sel_ff05|sel_ff06|sel_ff07), combinational
//  int_timer   out  1  one-clk interrupt request pulse
//  state_dbg   out  2  current FSM state (RUN=0, OVF=1, RELOAD=2)
// BEHAVIOUR
//  Reset (nreset=0, any time, async): TIMA=0, TMA=0, TAC[2:0]=0, edge_prev=0, cnt=0,
//   state=RUN, int_timer=0; d_out=0, d_oe=0 while no read. Reset mid-OVF drops pending reload/IRQ.
//  Tick source: t = TAC[2] & mux(TAC[1:0], taps); edge_prev <= t each clk.
//   inc = edge_prev & ~t (falling edge). TAC writes that take t 1->0 produce a real inc (DMG glitch).
//  Reads: FF05->TIMA, FF06->TMA, FF07->TAC_PAD|{5'b0,TAC}. Multiple sels: priority FF05>FF06>FF07.
//  FSM:
//   RUN: inc -> TIMA+1 (8-bit). If TIMA==FF at inc: TIMA<=00, cnt<=0, state<=OVF
//        (RELOAD_DELAY=0: TIMA<=TMA, int_timer=1 same clk, stay RUN).
//   OVF: TIMA holds 00; inc dropped. On mcyc: cnt+1; when cnt reaches RELOAD_DELAY-1 -> RELOAD.
//        CPU write FF05 in OVF: TIMA<=d_in, state<=RUN, no reload, no IRQ (cancel).
//   RELOAD: lasts exactly one M-cycle. On entry clk: TIMA<=TMA, int_timer=1 for one clk.
//        CPU write FF05 ignored; CPU write FF06 updates TMA and TIMA both to d_in.
//        inc dropped. Next mcyc -> RUN.
//  Simultaneous write FF05 and inc in RUN: write wins, inc lost, no overflow.
//  Write FF06 in RUN/OVF: TMA only. Write FF07: TAC<=d_in[2:0], any state.
//  Latency: write visible on read next clk; inc visible next clk.
//  int_timer never asserted more than once per overflow; never while nreset=0.
// TESTING
//  1 TAC=05, TIMA=00: 16 falling edges of div_262144 -> TIMA=10, int_timer never high.
//  2 TMA=A5, TIMA=FF, TAC=05: one edge -> TIMA=00 for 1 M-cycle, then TIMA=A5, int_timer 1-clk pulse.
//  3 As 2, write FF05=33 during 00 window -> TIMA=33, no reload, no int_timer.
//  4 As 2, write FF06=7E in RELOAD cycle -> TMA=7E, TIMA=7E; FF05 write there ignored.
//  5 TAC=05 with div_262144=1, write TAC=01 -> TIMA +1 once; TAC read returns F9.
//  6 Drop nreset while in OVF -> all regs 00, state RUN, no int_timer after release; d_oe=0.

Source files
------------

// File: rtl/timer_ctrl.sv
// FF05-FF07 timer sequencer: selects a divider tap per TAC, counts its falling edges into TIMA,
// runs the delayed TMA reload on overflow and owns the CPU read path for the three registers.
module timer_ctrl #(
  parameter int unsigned RELOAD_DELAY = 1,
  parameter logic [7:0]  TAC_PAD      = 8'hF8
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       mcyc,
  input  logic       div_4096,
  input  logic       div_262144,
  input  logic       div_65536,
  input  logic       div_16384,
  input  logic       sel_ff05,
  input  logic       sel_ff06,
  input  logic       sel_ff07,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       int_timer,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StOvf    = 2'd1,
    StReload = 2'd2
  } state_e;

  // Last OVF count value before the reload fires; unused when RELOAD_DELAY is 0.
  localparam logic [1:0] CntLast = (RELOAD_DELAY == 0) ? 2'd0 : 2'(RELOAD_DELAY - 1);

  state_e     state_q, state_d;
  logic [7:0] tima_q, tima_d;
  logic [7:0] tma_q, tma_d;
  logic [2:0] tac_q, tac_d;
  logic [1:0] cnt_q, cnt_d;
  logic       int_q, int_d;
  logic       edge_prev_q;

  logic tap_sel;
  logic tick;
  logic inc;
  logic wr_tima, wr_tma, wr_tac;

  always_comb begin
    tap_sel = 1'b0;
    case (tac_q[1:0])
      2'b00:   tap_sel = div_4096;
      2'b01:   tap_sel = div_262144;
      2'b10:   tap_sel = div_65536;
      default: tap_sel = div_16384;
    endcase
  end

  // Disabling the timer or switching taps while the tap is high counts as a falling edge.
  assign tick    = tac_q[2] & tap_sel;
  assign inc     = edge_prev_q & ~tick;
  assign wr_tima = cpu_wr & sel_ff05;
  assign wr_tma  = cpu_wr & sel_ff06;
  assign wr_tac  = cpu_wr & sel_ff07;

  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    tma_d   = tma_q;
    tac_d   = tac_q;
    cnt_d   = cnt_q;
    int_d   = 1'b0;

    if (wr_tac) tac_d = d_in[2:0];
    if (wr_tma) tma_d = d_in;

    unique case (state_q)
      StRun: begin
        if (wr_tima) begin
          tima_d = d_in;
        end else if (inc) begin
          if (tima_q == 8'hFF) begin
            if (RELOAD_DELAY == 0) begin
              tima_d = tma_d;
              int_d  = 1'b1;
            end else begin
              tima_d  = 8'h00;
              cnt_d   = 2'd0;
              state_d = StOvf;
            end
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      StOvf: begin
        // A TIMA write during the zero window cancels the pending reload and interrupt.
        if (wr_tima) begin
          tima_d  = d_in;
          state_d = StRun;
        end else if (mcyc) begin
          if (cnt_q == CntLast) begin
            tima_d  = tma_d;
            int_d   = 1'b1;
            state_d = StReload;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StReload: begin
        if (wr_tma) tima_d = d_in;
        if (mcyc) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StRun;
      tima_q      <= 8'h00;
      tma_q       <= 8'h00;
      tac_q       <= 3'b000;
      cnt_q       <= 2'd0;
      int_q       <= 1'b0;
      edge_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tima_q      <= tima_d;
      tma_q       <= tma_d;
      tac_q       <= tac_d;
      cnt_q       <= cnt_d;
      int_q       <= int_d;
      edge_prev_q <= tick;
    end
  end

  always_comb begin
    d_oe  = cpu_rd & (sel_ff05 | sel_ff06 | sel_ff07);
    d_out = 8'h00;
    if (d_oe) begin
      if (sel_ff05)      d_out = tima_q;
      else if (sel_ff06) d_out = tma_q;
      else               d_out = TAC_PAD | {5'b00000, tac_q};
    end
  end

  assign int_timer = int_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus randomized traffic, all checked every cycle
// against a register-level behavioural model of the timer.
module tb_timer_ctrl;

  localparam int unsigned RELOAD_DELAY = 1;
  localparam logic [2:0]  S05 = 3'b001;
  localparam logic [2:0]  S06 = 3'b010;
  localparam logic [2:0]  S07 = 3'b100;

  logic       clk = 1'b0;
  logic       nreset;
  logic       mcyc;
  logic [3:0] taps;
  logic       sel_ff05, sel_ff06, sel_ff07;
  logic       cpu_wr, cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       int_timer;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  timer_ctrl #(
    .RELOAD_DELAY(RELOAD_DELAY),
    .TAC_PAD     (8'hF8)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .mcyc      (mcyc),
    .div_4096  (taps[0]),
    .div_262144(taps[1]),
    .div_65536 (taps[2]),
    .div_16384 (taps[3]),
    .sel_ff05  (sel_ff05),
    .sel_ff06  (sel_ff06),
    .sel_ff07  (sel_ff07),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .d_in      (d_in),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .int_timer (int_timer),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int mc_cnt   = 0;

  // Model: ovf_left counts M-cycles left in the zero window (-1 = no overflow pending).
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  logic       m_prev, m_reload, m_int;
  int         m_ovf_left;

  logic [7:0] rd_val;
  logic       obs_int, obs_oe;
  logic [1:0] obs_state;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
    m_prev = 1'b0; m_reload = 1'b0; m_int = 1'b0; m_ovf_left = -1;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_reload) return 2'd2;
    if (m_ovf_left >= 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic void model_step();
    logic t, inc, w05, w06, w07;
    if (!nreset) begin
      model_reset();
      return;
    end
    t      = m_tac[2] & taps[m_tac[1:0]];
    inc    = m_prev & !t;
    m_prev = t;
    m_int  = 1'b0;
    w05 = cpu_wr & sel_ff05;
    w06 = cpu_wr & sel_ff06;
    w07 = cpu_wr & sel_ff07;
    if (w07) m_tac = d_in[2:0];
    if (w06) m_tma = d_in;
    if (m_reload) begin
      if (w06) m_tima = d_in;
      if (mcyc) m_reload = 1'b0;
    end else if (m_ovf_left >= 0) begin
      if (w05) begin
        m_tima     = d_in;
        m_ovf_left = -1;
      end else if (mcyc) begin
        m_ovf_left--;
        if (m_ovf_left == 0) begin
          m_ovf_left = -1;
          m_reload   = 1'b1;
          m_tima     = m_tma;
          m_int      = 1'b1;
        end
      end
    end else begin
      if (w05) m_tima = d_in;
      else if (inc) begin
        if (m_tima == 8'hFF) begin
          if (RELOAD_DELAY == 0) begin
            m_tima = m_tma;
            m_int  = 1'b1;
          end else begin
            m_tima     = 8'h00;
            m_ovf_left = RELOAD_DELAY;
          end
        end else begin
          m_tima = m_tima + 8'd1;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    logic       exp_oe;
    logic [7:0] exp_out;
    exp_oe  = cpu_rd & (sel_ff05 | sel_ff06 | sel_ff07);
    exp_out = 8'h00;
    if (exp_oe) begin
      if (sel_ff05)      exp_out = m_tima;
      else if (sel_ff06) exp_out = m_tma;
      else               exp_out = 8'hF8 | {5'b00000, m_tac};
    end
    check_eq("d_oe", {7'b0, d_oe}, {7'b0, exp_oe});
    check_eq("d_out", d_out, exp_out);
    check_eq("int_timer", {7'b0, int_timer}, {7'b0, m_int});
    check_eq("state_dbg", {6'b0, state_dbg}, {6'b0, model_state()});
    rd_val    = d_out;
    obs_int   = int_timer;
    obs_oe    = d_oe;
    obs_state = state_dbg;
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance the model at the rising edge.
  task automatic cycle(input logic [2:0] sel, input logic rd, input logic wr,
                       input logic [7:0] data);
    {sel_ff07, sel_ff06, sel_ff05} = sel;
    cpu_rd = rd;
    cpu_wr = wr;
    d_in   = data;
    mcyc   = (mc_cnt == 3);
    mc_cnt = (mc_cnt + 1) % 4;
    if (!nreset) model_reset();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(3'b000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] data);
    cycle(sel, 1'b0, 1'b1, data);
  endtask

  task automatic rd(input logic [2:0] sel);
    cycle(sel, 1'b1, 1'b0, 8'h00);
  endtask

  // Overflow TIMA on the rising edge that also carries mcyc, so the zero window is 4 clocks.
  task automatic setup_ovf(input logic [7:0] tma);
    taps = 4'b0000;
    wr(S07, 8'h05);
    wr(S06, tma);
    wr(S05, 8'hFF);
    for (int i = 0; i < 4 && mc_cnt != 2; i++) idle();
    taps[1] = 1'b1;
    idle();
    taps[1] = 1'b0;
    idle();
  endtask

  initial begin
    int pulses;
    nreset = 1'b0;
    taps   = 4'b0000;
    {sel_ff07, sel_ff06, sel_ff05} = 3'b000;
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    d_in   = 8'h00;
    mcyc   = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state
    rd(S05); check_eq("rst_tima", rd_val, 8'h00);
    rd(S07); check_eq("rst_tac", rd_val, 8'hF8);
    nreset = 1'b1;
    idle();

    // 1: 16 falling edges of div_262144
    wr(S07, 8'h05);
    wr(S05, 8'h00);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      taps[1] = 1'b1; idle(); if (obs_int) pulses++;
      taps[1] = 1'b0; idle(); if (obs_int) pulses++;
    end
    rd(S05); check_eq("t1_tima", rd_val, 8'h10);
    check_eq("t1_pulses", 8'(pulses), 8'd0);

    // 2: overflow, zero window, reload from TMA, single pulse
    setup_ovf(8'hA5);
    rd(S05); check_eq("t2_zero", rd_val, 8'h00);
    check_eq("t2_ovf_state", {6'b0, obs_state}, 8'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rd(S05);
      if (obs_int) pulses++;
    end
    check_eq("t2_pulses", 8'(pulses), 8'd1);
    check_eq("t2_tima", rd_val, 8'hA5);

    // 3: TIMA write during zero window cancels reload and interrupt
    setup_ovf(8'hA5);
    wr(S05, 8'h33);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rd(S05);
      if (obs_int) pulses++;
    end
    check_eq("t3_pulses", 8'(pulses), 8'd0);
    check_eq("t3_tima", rd_val, 8'h33);

    // 4: in RELOAD a TIMA write is ignored, a TMA write lands in both
    setup_ovf(8'hA5);
    for (int i = 0; i < 8 && obs_state != 2'd2; i++) idle();
    check_eq("t4_reload_seen", {6'b0, obs_state}, 8'd2);
    wr(S05, 8'h11);
    wr(S06, 8'h7E);
    rd(S05); check_eq("t4_tima", rd_val, 8'h7E);
    rd(S06); check_eq("t4_tma", rd_val, 8'h7E);

    // 5: disabling the timer with the tap high gives one increment
    taps = 4'b0000;
    wr(S07, 8'h05);
    wr(S05, 8'h40);
    taps[1] = 1'b1;
    idle();
    idle();
    wr(S07, 8'h01);
    idle();
    rd(S07); check_eq("t5_tac", rd_val, 8'hF9);
    rd(S05); check_eq("t5_tima", rd_val, 8'h41);

    // 6: reset during OVF
    setup_ovf(8'hA5);
    idle();
    check_eq("t6_in_ovf", {6'b0, obs_state}, 8'd1);
    nreset = 1'b0;
    idle();
    check_eq("t6_rst_state", {6'b0, obs_state}, 8'd0);
    check_eq("t6_rst_doe", {7'b0, obs_oe}, 8'd0);
    idle();
    nreset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (obs_int) pulses++;
    end
    check_eq("t6_pulses", 8'(pulses), 8'd0);
    rd(S05); check_eq("t6_tima", rd_val, 8'h00);
    rd(S06); check_eq("t6_tma", rd_val, 8'h00);
    rd(S07); check_eq("t6_tac", rd_val, 8'hF8);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int         op;
      logic [7:0] data;
      op   = $urandom_range(0, 9);
      data = 8'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) taps[k] = ~taps[k];
      nreset = ($urandom_range(0, 799) != 0);
      case (op)
        0, 1: rd(3'($urandom_range(1, 7)));
        2: begin
          if ($urandom_range(0, 1) == 1) data = 8'hFC | {6'b0, data[1:0]};
          wr(S05, data);
        end
        3: wr(S06, data);
        4: begin
          data[2] = ($urandom_range(0, 3) != 0);
          wr(S07, data);
        end
        5: cycle(3'($urandom_range(1, 7)), 1'b0, 1'b0, data);
        default: idle();
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
